bus_perf_monitor: RTL and testbench
===================================

// Module: bus_perf_monitor
// PURPOSE
//  Synthesizable, parametrised traffic/latency monitor snooping the per-device FIFO ports of bs_gnrtr_n_rbtr.
//  Timestamps each packet the bus pops from a source and matches it to its delivery push at the destination(s).
//  Accumulates per-destination message count, latency sum and max, plus global window cycles and delivered bits.
//  Hardware counterpart of the bench bandwidth/delay report, with broadcast fan-out and error detection.
// PARAMETERS
//  DEVS       5        number of device ports
//  PCKG_SZ    32       packet width; dest address = bits [PCKG_SZ-1 -: ADDR_BITS]
//  ADDR_BITS  8        destination address field width
//  BROADCAST  {ADDR_BITS{1'b1}}  broadcast address
//  TS_DEPTH   8        timestamp FIFO depth per destination (power of 2)
//  TS_W       32       timestamp/latency width
//  ACC_W      48       latency-sum and bit-count accumulator width
//  CNT_W      16       per-device message counter width
// PORTS
//  clk          in   1                 bus clock
//  reset        in   1                 synchronous, active-high reset
//  clear        in   1                 sync stats clear (all state except free-running timestamp)
//  freeze       in   1                 1 = ignore all traffic; counters hold
//  pop          in   DEVS              bus pops packet from source i
//  D_pop        in   DEVS*PCKG_SZ      packet at source i (slice i)
//  push         in   DEVS              bus delivers packet into device j
//  D_push       in   DEVS*PCKG_SZ      delivered packet at device j
//  stat_sel     in   $clog2(DEVS)      device whose stats are read out
//  stat_cnt     out  CNT_W             messages delivered to stat_sel
//  stat_lat_sum out  ACC_W             summed latency (cycles) to stat_sel
//  stat_lat_max out  TS_W              max latency to stat_sel
//  win_cycles   out  ACC_W             cycles from first capture after clear to now (not frozen)
//  tot_bits     out  ACC_W             PCKG_SZ * total deliveries
//  bad_addr_cnt out  CNT_W             pops with dest >= DEVS and != BROADCAST
//  err_ovf      out  1                 sticky: enqueue into full timestamp FIFO
//  err_unf      out  1                 sticky: delivery with empty timestamp FIFO
//  err_mis      out  1                 sticky: delivered dest field != j and != BROADCAST
// BEHAVIOUR
//  - Reset: all outputs, counters, FIFO pointers, flags = 0; ts counter = 0. clear: same except ts counter.
//  - ts counter: free-running TS_W, increments every cycle, wraps mod 2^TS_W.
//  - Capture (pop[i], not frozen): dest d valid (<DEVS) -> enqueue ts into FIFO d.
//    d == BROADCAST -> enqueue ts into every FIFO k != i, same cycle.
//    Invalid d -> bad_addr_cnt++, nothing enqueued. Several pops same cycle: all captured.
//    Two pops targeting same FIFO in one cycle: enqueue lower source index first.
//  - Delivery (push[j], not frozen): FIFO j non-empty -> dequeue head h; lat = ts - h (unsigned, wrap-safe).
//    cnt[j]++, lat_sum[j] += lat, lat_max[j] = max; tot_bits += PCKG_SZ. Empty -> err_unf, no stat update.
//    Dest field of D_push[j] checked: mismatch -> err_mis (stats still updated).
//  - Same-cycle enqueue+dequeue on one FIFO: allowed when non-empty; if empty, delivery = underflow
//    (capture lands, delivery does not use it). Full FIFO + same-cycle dequeue: enqueue accepted.
//  - Full without dequeue: enqueue dropped, err_ovf set.
//  - win_cycles: idle until first capture after reset/clear; then +1 per non-frozen cycle.
//  - Accumulators and counters saturate at all-ones; never wrap.
//  - Readout: stat_* registered, 1-cycle latency from stat_sel; stat_sel >= DEVS -> zeros.
//  - freeze masks capture/delivery/win_cycles; FIFOs hold contents; ts counter still runs.
//  - reset or clear mid-traffic: in-flight timestamps discarded; later deliveries are underflows.
// TESTING
//  1 pop[0] dest 2 at ts=10, push[2] at ts=25 -> cnt[2]=1, lat_sum=15, lat_max=15, tot_bits=32.
//  2 pop[1] dest 0xFF (DEVS=5) at ts=4; push[0],[2],[3],[4] at ts=9..12 -> cnt=1 each,
//    lat 5,6,7,8; cnt[1]=0.
//  3 9 pops to dest 3 without delivery (TS_DEPTH=8) -> err_ovf=1; 8 pushes to 3 -> cnt[3]=8, no err_unf.
//  4 push[4] with no capture -> err_unf=1, cnt[4]=0; pop dest 7 -> bad_addr_cnt=1, FIFOs unchanged.
//  5 ts preset near 2^TS_W-3: capture at 0xFFFFFFFD, deliver at ts=2 -> lat=5.
//  6 freeze=1 during pop/push -> no stat change; clear then first pop -> win_cycles starts from 0;
//    stat_sel change -> new values next cycle.

Source files
------------

// File: rtl/bus_perf_monitor_if.sv
// Snoop view of the bus FIFO ports: pops taken from sources, pushes delivered into devices.
interface bus_perf_monitor_if #(
  parameter int DEVS    = 5,
  parameter int PCKG_SZ = 32
);
  logic [DEVS-1:0]         pop;
  logic [DEVS*PCKG_SZ-1:0] D_pop;
  logic [DEVS-1:0]         push;
  logic [DEVS*PCKG_SZ-1:0] D_push;

  modport master (output pop, D_pop, push, D_push);
  modport slave  (input  pop, D_pop, push, D_push);
endinterface

// File: rtl/bus_perf_monitor.sv
// Traffic/latency monitor: timestamps source pops, matches them to destination pushes and keeps
// per-destination count/latency stats plus window, delivered-bit and error counters.
module bus_perf_monitor #(
  parameter int                   DEVS      = 5,
  parameter int                   PCKG_SZ   = 32,
  parameter int                   ADDR_BITS = 8,
  parameter logic [ADDR_BITS-1:0] BROADCAST = {ADDR_BITS{1'b1}},
  parameter int                   TS_DEPTH  = 8,
  parameter int                   TS_W      = 32,
  parameter int                   ACC_W     = 48,
  parameter int                   CNT_W     = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      freeze,
  bus_perf_monitor_if.slave         bus,
  input  logic [$clog2(DEVS)-1:0]   stat_sel,
  output logic [CNT_W-1:0]          stat_cnt,
  output logic [ACC_W-1:0]          stat_lat_sum,
  output logic [TS_W-1:0]           stat_lat_max,
  output logic [ACC_W-1:0]          win_cycles,
  output logic [ACC_W-1:0]          tot_bits,
  output logic [CNT_W-1:0]          bad_addr_cnt,
  output logic                      err_ovf,
  output logic                      err_unf,
  output logic                      err_mis
);
  localparam int PTR_W = $clog2(TS_DEPTH);
  localparam int OCC_W = PTR_W + 1;

  logic [TS_W-1:0]      ts;
  logic [TS_W-1:0]      mem     [DEVS][TS_DEPTH];
  logic [PTR_W-1:0]     wr_ptr  [DEVS];
  logic [PTR_W-1:0]     rd_ptr  [DEVS];
  logic [OCC_W-1:0]     occ     [DEVS];
  logic [CNT_W-1:0]     cnt     [DEVS];
  logic [ACC_W-1:0]     lat_sum [DEVS];
  logic [TS_W-1:0]      lat_max [DEVS];
  logic                 win_act;

  logic [ADDR_BITS-1:0] pop_dst  [DEVS];
  logic [ADDR_BITS-1:0] push_dst [DEVS];
  logic [TS_W-1:0]      lat      [DEVS];
  logic [DEVS-1:0]      deq;
  int                   n_acc    [DEVS];
  int                   n_req, space, n_bad, n_deq;
  logic                 cap_any, ovf_any, unf_any, mis_any;

  function automatic logic [ACC_W-1:0] sat_acc(input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b);
    logic [ACC_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[ACC_W] ? '1 : s[ACC_W-1:0];
  endfunction

  function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  // All pops in one cycle carry the same timestamp, so per-FIFO enqueue order reduces to a count.
  always_comb begin
    cap_any = 1'b0;
    ovf_any = 1'b0;
    unf_any = 1'b0;
    mis_any = 1'b0;
    n_bad   = 0;
    n_deq   = 0;
    n_req   = 0;
    space   = 0;
    deq     = '0;
    for (int i = 0; i < DEVS; i++) begin
      pop_dst[i]  = bus.D_pop[i*PCKG_SZ + PCKG_SZ - 1 -: ADDR_BITS];
      push_dst[i] = bus.D_push[i*PCKG_SZ + PCKG_SZ - 1 -: ADDR_BITS];
    end
    for (int i = 0; i < DEVS; i++) begin
      if (bus.pop[i] && !freeze) begin
        if (pop_dst[i] == BROADCAST || int'(pop_dst[i]) < DEVS) cap_any = 1'b1;
        else                                                   n_bad++;
      end
    end
    for (int k = 0; k < DEVS; k++) begin
      lat[k] = ts - mem[k][rd_ptr[k]];
      n_req  = 0;
      for (int i = 0; i < DEVS; i++) begin
        if (bus.pop[i] && !freeze &&
            (pop_dst[i] == ADDR_BITS'(k) || (pop_dst[i] == BROADCAST && i != k)))
          n_req++;
      end
      if (bus.push[k] && !freeze) begin
        if (occ[k] == '0) unf_any = 1'b1;
        else begin
          deq[k] = 1'b1;
          n_deq++;
        end
        if (push_dst[k] != ADDR_BITS'(k) && push_dst[k] != BROADCAST) mis_any = 1'b1;
      end
      // A same-cycle dequeue frees a slot for this cycle's capture.
      space = TS_DEPTH - int'(occ[k]) + int'(deq[k]);
      if (n_req > space) begin
        n_acc[k] = space;
        ovf_any  = 1'b1;
      end else begin
        n_acc[k] = n_req;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ts <= '0;
    else       ts <= ts + TS_W'(1);
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < DEVS; k++)
      for (int e = 0; e < TS_DEPTH; e++)
        if (((e - int'(wr_ptr[k])) & (TS_DEPTH - 1)) < n_acc[k]) mem[k][e] <= ts;
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      for (int k = 0; k < DEVS; k++) begin
        wr_ptr[k]  <= '0;
        rd_ptr[k]  <= '0;
        occ[k]     <= '0;
        cnt[k]     <= '0;
        lat_sum[k] <= '0;
        lat_max[k] <= '0;
      end
      win_act      <= 1'b0;
      win_cycles   <= '0;
      tot_bits     <= '0;
      bad_addr_cnt <= '0;
      err_ovf      <= 1'b0;
      err_unf      <= 1'b0;
      err_mis      <= 1'b0;
      stat_cnt     <= '0;
      stat_lat_sum <= '0;
      stat_lat_max <= '0;
    end else begin
      for (int k = 0; k < DEVS; k++) begin
        wr_ptr[k] <= wr_ptr[k] + PTR_W'(n_acc[k]);
        rd_ptr[k] <= rd_ptr[k] + PTR_W'(deq[k]);
        occ[k]    <= occ[k] + OCC_W'(n_acc[k]) - OCC_W'(deq[k]);
        if (deq[k]) begin
          cnt[k]     <= sat_cnt(cnt[k], CNT_W'(1));
          lat_sum[k] <= sat_acc(lat_sum[k], ACC_W'(lat[k]));
          if (lat[k] > lat_max[k]) lat_max[k] <= lat[k];
        end
      end
      if (cap_any) win_act <= 1'b1;
      if (win_act && !freeze) win_cycles <= sat_acc(win_cycles, ACC_W'(1));
      tot_bits     <= sat_acc(tot_bits, ACC_W'(n_deq * PCKG_SZ));
      bad_addr_cnt <= sat_cnt(bad_addr_cnt, CNT_W'(n_bad));
      err_ovf      <= err_ovf | ovf_any;
      err_unf      <= err_unf | unf_any;
      err_mis      <= err_mis | mis_any;
      if (int'(stat_sel) < DEVS) begin
        stat_cnt     <= cnt[stat_sel];
        stat_lat_sum <= lat_sum[stat_sel];
        stat_lat_max <= lat_max[stat_sel];
      end else begin
        stat_cnt     <= '0;
        stat_lat_sum <= '0;
        stat_lat_max <= '0;
      end
    end
  end
endmodule

// File: tb/tb_bus_perf_monitor.sv
// Bench for bus_perf_monitor: directed corner cases, a readout table and a randomized run,
// all scored every cycle against a queue-based reference model.
module tb_bus_perf_monitor;
  localparam int     DEVS    = 5;
  localparam int     PW      = 32;
  localparam int     AB      = 8;
  localparam int     DEPTH   = 8;
  localparam int     TSW     = 8;
  localparam int     ACCW    = 24;
  localparam int     CNTW    = 5;
  localparam int     TS_MOD  = 256;
  localparam longint ACC_MAX = (64'd1 << ACCW) - 1;
  localparam longint CNT_MAX = (64'd1 << CNTW) - 1;

  logic            clk = 1'b0;
  logic            reset, clear, freeze;
  logic [2:0]      stat_sel;
  logic [CNTW-1:0] stat_cnt, bad_addr_cnt;
  logic [ACCW-1:0] stat_lat_sum, win_cycles, tot_bits;
  logic [TSW-1:0]  stat_lat_max;
  logic            err_ovf, err_unf, err_mis;

  bus_perf_monitor_if #(.DEVS(DEVS), .PCKG_SZ(PW)) bif ();

  bus_perf_monitor #(
    .DEVS(DEVS), .PCKG_SZ(PW), .ADDR_BITS(AB), .TS_DEPTH(DEPTH),
    .TS_W(TSW), .ACC_W(ACCW), .CNT_W(CNTW)
  ) dut (
    .clk(clk), .reset(reset), .clear(clear), .freeze(freeze), .bus(bif.slave),
    .stat_sel(stat_sel), .stat_cnt(stat_cnt), .stat_lat_sum(stat_lat_sum),
    .stat_lat_max(stat_lat_max), .win_cycles(win_cycles), .tot_bits(tot_bits),
    .bad_addr_cnt(bad_addr_cnt), .err_ovf(err_ovf), .err_unf(err_unf), .err_mis(err_mis)
  );

  always #5 clk = ~clk;

  // reference model state
  int     q [DEVS][$];
  longint m_cnt [DEVS];
  longint m_sum [DEVS];
  longint m_max [DEVS];
  longint m_win, m_bits, m_bad, e_cnt, e_sum, e_max;
  bit     m_win_act, m_ovf, m_unf, m_mis;
  int     m_ts;
  int     n_chk = 0;
  int     n_pass = 0;

  typedef struct {
    int     sel;
    longint cnt;
    longint sum;
    longint mx;
  } rd_vec_t;
  rd_vec_t tbl [7];

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
  endtask

  task automatic model_zero();
    for (int k = 0; k < DEVS; k++) begin
      q[k].delete();
      m_cnt[k] = 0; m_sum[k] = 0; m_max[k] = 0;
    end
    m_win = 0; m_bits = 0; m_bad = 0; e_cnt = 0; e_sum = 0; e_max = 0;
    m_win_act = 0; m_ovf = 0; m_unf = 0; m_mis = 0;
  endtask

  task automatic enq(input int k);
    if (q[k].size() < DEPTH) q[k].push_back(m_ts);
    else m_ovf = 1;
  endtask

  // Deliveries are taken before captures: a same-cycle dequeue frees room, and a capture
  // into an empty FIFO cannot satisfy a delivery in the same cycle.
  task automatic model_step();
    int d, h, lat;
    bit cap;
    if (reset || clear) begin
      model_zero();
      m_ts = reset ? 0 : (m_ts + 1) % TS_MOD;
      return;
    end
    if (stat_sel < DEVS) begin
      e_cnt = m_cnt[stat_sel]; e_sum = m_sum[stat_sel]; e_max = m_max[stat_sel];
    end else begin
      e_cnt = 0; e_sum = 0; e_max = 0;
    end
    if (!freeze) begin
      if (m_win_act) m_win = (m_win < ACC_MAX) ? m_win + 1 : ACC_MAX;
      for (int j = 0; j < DEVS; j++) begin
        if (bif.push[j]) begin
          d = int'(bif.D_push[j*PW + PW - 1 -: AB]);
          if (d != j && d != 255) m_mis = 1;
          if (q[j].size() == 0) m_unf = 1;
          else begin
            h   = q[j].pop_front();
            lat = (m_ts - h + TS_MOD) % TS_MOD;
            m_cnt[j] = (m_cnt[j] < CNT_MAX) ? m_cnt[j] + 1 : CNT_MAX;
            m_sum[j] = (m_sum[j] + lat < ACC_MAX) ? m_sum[j] + lat : ACC_MAX;
            if (lat > m_max[j]) m_max[j] = lat;
            m_bits = (m_bits + PW < ACC_MAX) ? m_bits + PW : ACC_MAX;
          end
        end
      end
      cap = 0;
      for (int i = 0; i < DEVS; i++) begin
        if (bif.pop[i]) begin
          d = int'(bif.D_pop[i*PW + PW - 1 -: AB]);
          if (d == 255) begin
            cap = 1;
            for (int k = 0; k < DEVS; k++) if (k != i) enq(k);
          end else if (d < DEVS) begin
            cap = 1;
            enq(d);
          end else begin
            m_bad = (m_bad < CNT_MAX) ? m_bad + 1 : CNT_MAX;
          end
        end
      end
      if (cap) m_win_act = 1;
    end
    m_ts = (m_ts + 1) % TS_MOD;
  endtask

  task automatic check_all();
    chk("stat_cnt", stat_cnt, e_cnt);
    chk("stat_lat_sum", stat_lat_sum, e_sum);
    chk("stat_lat_max", stat_lat_max, e_max);
    chk("win_cycles", win_cycles, m_win);
    chk("tot_bits", tot_bits, m_bits);
    chk("bad_addr_cnt", bad_addr_cnt, m_bad);
    chk("err_ovf", err_ovf, m_ovf);
    chk("err_unf", err_unf, m_unf);
    chk("err_mis", err_mis, m_mis);
  endtask

  task automatic idle();
    bif.pop = '0; bif.push = '0; bif.D_pop = '0; bif.D_push = '0;
    reset = 0; clear = 0; freeze = 0;
  endtask

  task automatic src(input int i, input int dst);
    bif.pop[i] = 1'b1;
    bif.D_pop[i*PW +: PW] = {8'(dst), 24'($urandom)};
  endtask

  task automatic dpush(input int j, input int fld);
    bif.push[j] = 1'b1;
    bif.D_push[j*PW +: PW] = {8'(fld), 24'($urandom)};
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_all();
    idle();
  endtask

  task automatic idle_n(input int n);
    for (int c = 0; c < n; c++) cycle();
  endtask

  task automatic do_clear();
    clear = 1;
    cycle();
  endtask

  task automatic readout(input string name, input int sel, input longint c, input longint s, input longint m);
    stat_sel = 3'(sel);
    cycle();
    chk({name, "_cnt"}, stat_cnt, c);
    chk({name, "_sum"}, stat_lat_sum, s);
    chk({name, "_max"}, stat_lat_max, m);
  endtask

  task automatic wait_ts(input int target);
    for (int n = 0; n < 2 * TS_MOD && m_ts != target; n++) cycle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, d, f;
    m_ts = 0;
    model_zero();
    idle();
    stat_sel = 3'd0;
    reset = 1; cycle();
    reset = 1; cycle();
    chk("rst_win", win_cycles, 0);
    chk("rst_bits", tot_bits, 0);
    chk("rst_cnt", stat_cnt, 0);
    chk("rst_err", {err_ovf, err_unf, err_mis}, 0);

    // unicast: lat 15, then broadcast from source 1: lat 5..8
    src(0, 2); cycle();
    idle_n(14);
    dpush(2, 2); cycle();
    chk("uni_bits", tot_bits, 32);
    src(1, 255); cycle();
    idle_n(4);
    dpush(0, 0); cycle();
    dpush(2, 2); cycle();
    dpush(3, 3); cycle();
    dpush(4, 4); cycle();
    chk("bc_bits", tot_bits, 160);
    tbl[0] = '{0, 1, 5, 5};
    tbl[1] = '{1, 0, 0, 0};
    tbl[2] = '{2, 2, 21, 15};
    tbl[3] = '{3, 1, 7, 7};
    tbl[4] = '{4, 1, 8, 8};
    tbl[5] = '{5, 0, 0, 0};
    tbl[6] = '{7, 0, 0, 0};
    for (int t = 0; t < 7; t++) readout("tbl", tbl[t].sel, tbl[t].cnt, tbl[t].sum, tbl[t].mx);

    // underflow, bad address, dest mismatch
    dpush(4, 4); cycle();
    chk("unf_flag", err_unf, 1);
    src(0, 7); cycle();
    chk("bad_cnt", bad_addr_cnt, 1);
    readout("unf4", 4, 1, 8, 8);
    src(0, 3); cycle();
    dpush(3, 1); cycle();
    chk("mis_flag", err_mis, 1);

    // overflow: 9 captures into an 8-deep FIFO, 8 deliveries of lat 9
    do_clear();
    for (int n = 0; n < 9; n++) begin src(0, 3); cycle(); end
    chk("ovf_flag", err_ovf, 1);
    for (int n = 0; n < 8; n++) begin dpush(3, 3); cycle(); end
    chk("ovf_no_unf", err_unf, 0);
    readout("ovf3", 3, 8, 72, 9);

    // two direct pops plus a broadcast into FIFO 2 in one cycle
    do_clear();
    src(0, 2); src(1, 2); src(4, 255); cycle();
    cycle();
    for (int n = 0; n < 3; n++) begin dpush(2, 2); cycle(); end
    readout("multi2", 2, 3, 9, 4);

    // full FIFO with same-cycle dequeue accepts the capture; without dequeue it overflows
    do_clear();
    for (int n = 0; n < 8; n++) begin src(0, 1); cycle(); end
    src(0, 1); dpush(1, 1); cycle();
    chk("full_deq_ok", err_ovf, 0);
    src(0, 1); cycle();
    chk("full_ovf", err_ovf, 1);

    // empty FIFO: same-cycle capture lands but the delivery underflows
    do_clear();
    src(0, 4); dpush(4, 4); cycle();
    chk("empty_unf", err_unf, 1);
    dpush(4, 4); cycle();
    readout("empty4", 4, 1, 1, 1);

    // timestamp wrap
    do_clear();
    wait_ts(TS_MOD - 3);
    src(0, 1); cycle();
    wait_ts(2);
    dpush(1, 1); cycle();
    readout("wrap", 1, 1, 5, 5);

    // freeze masks traffic and window; FIFO contents survive
    do_clear();
    freeze = 1; src(0, 2); dpush(3, 3); cycle();
    chk("frz_unf", err_unf, 0);
    chk("frz_win", win_cycles, 0);
    src(0, 2); cycle();
    chk("win_start", win_cycles, 0);
    idle_n(3);
    chk("win_run", win_cycles, 3);
    freeze = 1; dpush(2, 2); cycle();
    freeze = 1; cycle();
    chk("win_frz", win_cycles, 3);
    readout("frz2", 2, 0, 0, 0);
    dpush(2, 2); cycle();
    readout("thaw2", 2, 1, 7, 7);

    // saturation of the narrow counters
    do_clear();
    for (int n = 0; n < 40; n++) begin src(0, 6); cycle(); end
    chk("bad_sat", bad_addr_cnt, CNT_MAX);
    src(1, 0); cycle();
    for (int n = 0; n < 40; n++) begin src(1, 0); dpush(0, 0); cycle(); end
    readout("cnt_sat", 0, CNT_MAX, 40, 1);

    // randomized traffic
    do_clear();
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < DEVS; i++) begin
        if ($urandom_range(99) < 30) begin
          r = $urandom_range(99);
          d = (r < 70) ? $urandom_range(DEVS - 1) : (r < 85) ? 255 : $urandom_range(7, 5);
          src(i, d);
        end
      end
      for (int j = 0; j < DEVS; j++) begin
        if ($urandom_range(99) < 35) begin
          r = $urandom_range(99);
          f = (r < 92) ? j : (r < 96) ? 255 : (j + 1) % DEVS;
          dpush(j, f);
        end
      end
      freeze   = ($urandom_range(99) < 5);
      clear    = ($urandom_range(299) == 0);
      stat_sel = 3'($urandom_range(7));
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
